// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory port arbiter.
// Holds the FSM state encoding and the grant index width helper.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    localparam int MIN_IDX_W = 1;

    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return MIN_IDX_W;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    int cand_s;

    // Scan from rr_ptr upward, wrapping once, and keep the first hit
    always_comb begin
        found  = 1'b0;
        index  = {IDX_W{1'b0}};
        cand_s = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = int'(rr_ptr) + k;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            if (!found && eligible[cand_s]) begin
                found = 1'b1;
                index = IDX_W'(cand_s);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory backend port between NUM_REQ requesters with round-robin
// arbitration, one outstanding transaction, and sticky per-requester done/data.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_r_en,
    input  logic [NUM_REQ-1:0]          req_w_en,
    input  logic [NUM_REQ-1:0]          req_avail,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_ptr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_store,
    input  logic [NUM_REQ-1:0]          req_write_through,
    output logic [NUM_REQ-1:0]          req_done,
    output logic [NUM_REQ*DATA_W-1:0]   req_data_load,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_write_through,
    input  logic                        mem_ack,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t          state_r;
    logic [IDX_W-1:0]    rr_ptr_r;
    logic [NUM_REQ-1:0]  eligible_s;
    logic                found_s;
    logic [IDX_W-1:0]    pick_s;

    assign eligible_s = req_avail & (req_r_en | req_w_en) & ~req_done;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .eligible (eligible_s),
        .rr_ptr   (rr_ptr_r),
        .found    (found_s),
        .index    (pick_s)
    );

    // Arbiter FSM with registered backend outputs and sticky done/data slots
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= IDLE;
            rr_ptr_r          <= {IDX_W{1'b0}};
            req_done          <= {NUM_REQ{1'b0}};
            req_data_load     <= {(NUM_REQ*DATA_W){1'b0}};
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_addr          <= {ADDR_W{1'b0}};
            mem_wdata         <= {DATA_W{1'b0}};
            mem_write_through <= 1'b0;
            busy              <= 1'b0;
            grant_id          <= {IDX_W{1'b0}};
        end else begin
            // Done clears whenever its owner lets go of avail; the set below
            // only fires for a grantee that still holds avail, so no conflict.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_avail[i]) begin
                    req_done[i] <= 1'b0;
                end
            end
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        grant_id          <= pick_s;
                        mem_addr          <= req_ptr[int'(pick_s)*ADDR_W +: ADDR_W];
                        mem_wdata         <= req_data_store[int'(pick_s)*DATA_W +: DATA_W];
                        mem_we            <= req_w_en[pick_s];
                        mem_write_through <= req_write_through[pick_s];
                        mem_req           <= 1'b1;
                        busy              <= 1'b1;
                        state_r           <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                        if (grant_id == IDX_W'(NUM_REQ - 1)) begin
                            rr_ptr_r <= {IDX_W{1'b0}};
                        end else begin
                            rr_ptr_r <= grant_id + IDX_W'(1);
                        end
                        if (req_avail[grant_id]) begin
                            req_done[grant_id] <= 1'b1;
                            if (!mem_we) begin
                                req_data_load[int'(grant_id)*DATA_W +: DATA_W] <= mem_rdata;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (NUM_REQ=4, 32-bit).
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_r_en, req_w_en, req_avail, req_write_through;
    logic [127:0] req_ptr, req_data_store;
    logic [3:0]   req_done;
    logic [127:0] req_data_load;
    logic         mem_req, mem_we, mem_write_through, mem_ack, busy;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [1:0]   grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_r_en(req_r_en), .req_w_en(req_w_en), .req_avail(req_avail),
        .req_ptr(req_ptr), .req_data_store(req_data_store),
        .req_write_through(req_write_through),
        .req_done(req_done), .req_data_load(req_data_load),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_write_through(mem_write_through),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_r_en = 4'h0; req_w_en = 4'h0; req_avail = 4'h0; req_write_through = 4'h0;
        req_ptr = 128'h0; req_data_store = 128'h0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({mem_req, busy, mem_we, mem_write_through} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_req, busy, mem_we, mem_write_through}); end
        n_checks++; if (req_done !== 4'h0) begin n_fail++; $display("FAIL reset_done: got %h expected 0", req_done); end
        n_checks++; if ({mem_addr, mem_wdata, grant_id} !== 66'h0) begin n_fail++; $display("FAIL reset_bus: got %h expected 0", {mem_addr, mem_wdata, grant_id}); end
        n_checks++; if (req_data_load !== 128'h0) begin n_fail++; $display("FAIL reset_load: got %h expected 0", req_data_load); end
    endtask

    task automatic test_single_read();
        do_reset();
        req_avail[2] = 1'b1; req_r_en[2] = 1'b1; req_ptr[64 +: 32] = 32'h40;
        tick();
        n_checks++; if ({mem_req, busy, mem_we, grant_id} !== 5'b11010) begin n_fail++; $display("FAIL t1_grant: got %b expected 11010", {mem_req, busy, mem_we, grant_id}); end
        n_checks++; if (mem_addr !== 32'h40) begin n_fail++; $display("FAIL t1_addr: got %h expected 40", mem_addr); end
        tick(); tick();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL t1_hold: got %b/%h expected 1/40", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h3F800000;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        n_checks++; if (req_done !== 4'b0100) begin n_fail++; $display("FAIL t1_done: got %b expected 0100", req_done); end
        n_checks++; if (req_data_load[64 +: 32] !== 32'h3F800000) begin n_fail++; $display("FAIL t1_data: got %h expected 3f800000", req_data_load[64 +: 32]); end
        n_checks++; if ({mem_req, busy} !== 2'b00) begin n_fail++; $display("FAIL t1_release: got %b expected 00", {mem_req, busy}); end
        tick();
        n_checks++; if (req_done !== 4'b0100 || mem_req !== 1'b0) begin n_fail++; $display("FAIL t1_sticky: got %b/%b expected 0100/0", req_done, mem_req); end
        req_avail[2] = 1'b0; req_r_en[2] = 1'b0;
        tick();
        n_checks++; if (req_done !== 4'b0000) begin n_fail++; $display("FAIL t1_clear: got %b expected 0000", req_done); end
        n_checks++; if (req_data_load[64 +: 32] !== 32'h3F800000) begin n_fail++; $display("FAIL t1_keep: got %h expected 3f800000", req_data_load[64 +: 32]); end
    endtask

    task automatic test_relu_pair();
        do_reset();
        req_avail = 4'b1001; req_r_en[0] = 1'b1; req_w_en[3] = 1'b1; req_write_through[3] = 1'b1;
        req_ptr[0 +: 32] = 32'h10; req_ptr[96 +: 32] = 32'h80; req_data_store[96 +: 32] = 32'hDEADBEEF;
        tick();
        n_checks++; if ({mem_req, mem_we, grant_id, mem_addr} !== {1'b1, 1'b0, 2'd0, 32'h10}) begin n_fail++; $display("FAIL t2_first: got %b %b %0d %h expected 1 0 0 10", mem_req, mem_we, grant_id, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (req_done !== 4'b0001 || req_data_load[0 +: 32] !== 32'h11112222) begin n_fail++; $display("FAIL t2_done0: got %b %h expected 0001 11112222", req_done, req_data_load[0 +: 32]); end
        tick();
        n_checks++; if ({mem_req, mem_we, mem_write_through, grant_id} !== 5'b11111) begin n_fail++; $display("FAIL t2_second: got %b expected 11111", {mem_req, mem_we, mem_write_through, grant_id}); end
        n_checks++; if (mem_addr !== 32'h80 || mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t2_wbus: got %h %h expected 80 deadbeef", mem_addr, mem_wdata); end
        n_checks++; if (req_done !== 4'b0001) begin n_fail++; $display("FAIL t2_wait_done: got %b expected 0001", req_done); end
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (req_done !== 4'b1001) begin n_fail++; $display("FAIL t2_both: got %b expected 1001", req_done); end
        n_checks++; if (req_data_load[96 +: 32] !== 32'h0) begin n_fail++; $display("FAIL t2_wslot: got %h expected 0", req_data_load[96 +: 32]); end
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        do_reset();
        req_avail = 4'hF; req_r_en = 4'hF;
        for (int i = 0; i < 4; i++) req_ptr[i*32 +: 32] = 32'h100 + i;
        tick();
        for (int n = 0; n < 5; n++) begin
            g = 2'(n % 4);
            n_checks++; if (mem_req !== 1'b1 || grant_id !== g || mem_addr !== 32'h100 + 32'(g)) begin n_fail++; $display("FAIL t3_order%0d: got %b %0d %h expected 1 %0d %h", n, mem_req, grant_id, mem_addr, g, 32'h100 + 32'(g)); end
            mem_ack = 1'b1; mem_rdata = 32'hA0 + 32'(n);
            if (n > 0) req_avail[2'(n - 1)] = 1'b1;
            tick();
            mem_ack = 1'b0;
            n_checks++; if (req_done[g] !== 1'b1) begin n_fail++; $display("FAIL t3_done%0d: got %b expected 1", n, req_done[g]); end
            req_avail[g] = 1'b0;
            tick();
        end
    endtask

    task automatic test_abort();
        do_reset();
        req_avail[1] = 1'b1; req_r_en[1] = 1'b1; req_ptr[32 +: 32] = 32'h24;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
        tick();
        mem_ack = 1'b0;
        req_avail[1] = 1'b0;
        tick();
        req_avail[1] = 1'b1;
        tick();
        n_checks++; if (mem_req !== 1'b1 || grant_id !== 2'd1) begin n_fail++; $display("FAIL t4_regrant: got %b %0d expected 1 1", mem_req, grant_id); end
        req_avail[1] = 1'b0;
        tick();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL t4_hold: got %b expected 1", mem_req); end
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (req_done !== 4'b0000 || mem_req !== 1'b0) begin n_fail++; $display("FAIL t4_nodone: got %b %b expected 0000 0", req_done, mem_req); end
        n_checks++; if (req_data_load[32 +: 32] !== 32'hAAAA5555) begin n_fail++; $display("FAIL t4_slot: got %h expected aaaa5555", req_data_load[32 +: 32]); end
        req_avail = 4'b0101; req_r_en = 4'b0101;
        tick();
        n_checks++; if (mem_req !== 1'b1 || grant_id !== 2'd2) begin n_fail++; $display("FAIL t4_next: got %b %0d expected 1 2", mem_req, grant_id); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        req_avail[0] = 1'b1; req_r_en[0] = 1'b1; req_ptr[0 +: 32] = 32'h44; req_write_through[0] = 1'b1;
        tick();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL t5_req: got %b expected 1", mem_req); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_avail[0] = 1'b0; req_r_en[0] = 1'b0;
        n_checks++; if ({mem_req, busy, mem_write_through, grant_id, mem_addr} !== 37'h0) begin n_fail++; $display("FAIL t5_clear: got %h expected 0", {mem_req, busy, mem_write_through, grant_id, mem_addr}); end
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (req_done !== 4'h0 || req_data_load !== 128'h0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL t5_stray: got %b %h %b expected 0 0 0", req_done, req_data_load, mem_req); end
    endtask

    task automatic test_rw_both();
        do_reset();
        req_avail[0] = 1'b1; req_r_en[0] = 1'b1; req_w_en[0] = 1'b1;
        req_ptr[0 +: 32] = 32'h20; req_data_store[0 +: 32] = 32'hCAFEF00D;
        tick();
        n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'hCAFEF00D || mem_addr !== 32'h20) begin n_fail++; $display("FAIL t6_write: got %b %h %h expected 1 cafef00d 20", mem_we, mem_wdata, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h55;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (req_done !== 4'b0001 || req_data_load[0 +: 32] !== 32'h0) begin n_fail++; $display("FAIL t6_done: got %b %h expected 0001 0", req_done, req_data_load[0 +: 32]); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_relu_pair();
        test_round_robin();
        test_abort();
        test_reset_mid_wait();
        test_rw_both();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one memory backend port between NUM_REQ mem_handle-style requesters, such as the a/b/c/d handles of an FPU op like ReLU backward.
- Round-robin arbitration, one outstanding transaction at a time.
- Per-requester done and read data are sticky until that requester drops avail. This lets an op wait on several handles at once, e.g. a.done && d.done.
- Sits between the FPU op modules and the memory controller.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, pointer/address width
DATA_W, 32, data word width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_r_en  in  NUM_REQ  per-requester read request
req_w_en  in  NUM_REQ  per-requester write request
req_avail  in  NUM_REQ  per-requester transaction valid
req_ptr  in  NUM_REQ*ADDR_W  per-requester address, requester i at [i*ADDR_W +: ADDR_W]
req_data_store  in  NUM_REQ*DATA_W  per-requester write data
req_write_through  in  NUM_REQ  per-requester write-through hint
req_done  out  NUM_REQ  per-requester sticky completion
req_data_load  out  NUM_REQ*DATA_W  per-requester latched read data
mem_req  out  1  backend request, held until mem_ack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  backend address
mem_wdata  out  DATA_W  backend write data
mem_write_through  out  1  forwarded hint
mem_ack  in  1  backend completion, 1-cycle pulse
mem_rdata  in  DATA_W  read data, valid with mem_ack
busy  out  1  transaction outstanding
grant_id  out  $clog2(NUM_REQ)  current or last grantee

Behaviour:
- Eligibility: requester i is eligible when req_avail[i] & (req_r_en[i] | req_w_en[i]) & ~req_done[i]. If both r_en and w_en are set, the request is a write.
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - All outputs 0: req_done, req_data_load, mem_req, mem_we, mem_addr, mem_wdata, mem_write_through, busy, grant_id.
  - Round-robin pointer = 0.
  - Reset mid-transaction drops mem_req the next cycle. A later stray mem_ack is ignored.
- FSM:
  - IDLE:
    - If any requester is eligible, pick the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
    - Register grant_id, mem_addr, mem_wdata, mem_we, mem_write_through. Assert mem_req and busy. Go to WAIT.
    - mem_ack while in IDLE is ignored.
  - WAIT:
    - Hold mem_req and all mem_* stable until mem_ack.
    - On mem_ack: deassert mem_req and busy; rr_ptr = (grant_id+1) mod NUM_REQ.
    - If req_avail[grant_id] is still 1: set req_done[grant_id]. For a read, also latch mem_rdata into the grantee's req_data_load slot.
    - If req_avail[grant_id] was dropped during WAIT: abort. The transaction still completes on the backend, but done is not set and data is discarded.
    - Go to IDLE.
- Latency: request eligible at edge t -> mem_req high after edge t+1. mem_ack sampled at edge t+k -> req_done visible after edge t+k. Back-to-back grants have 1 IDLE cycle between transactions.
- Done clear: req_done[i] clears on the first edge where req_avail[i]=0. req_data_load slot i keeps its value until the next read completes for i. A requester may reassert avail the cycle after clearing and is then eligible again.
- Simultaneous events:
  - Done set for the grantee and done clear for a different requester in the same cycle are independent.
  - avail dropping on the same edge as mem_ack counts as an abort.
- Fairness: with all requesters continuously eligible, each is served once per NUM_REQ grants.
- Writes carry no data back; their slot in req_data_load is unchanged.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum {IDLE, WAIT} arb_state_t
  - localparam helpers for the grant index width
- Sub-module rr_picker (parameter NUM_REQ): combinational. Inputs eligible vector and rr_ptr; outputs found and index. Unit-testable on its own.

Test Plan:
1. Single read: requester 2 reads ptr 0x40, backend acks after 3 cycles with 0x3F800000 -> req_done[2]=1 and slot 2 = 0x3F800000 while avail is held; done clears the cycle after avail drops.
2. ReLU-style pair: req 0 reads 0x10 and req 3 writes 0xDEADBEEF to 0x80 in the same cycle -> req 0 granted first, then req 3; req_done[0] stays 1 until req_done[3]=1, so both are high together.
3. Round-robin: all 4 eligible continuously, immediate acks -> grant order 0,1,2,3,0; no requester is starved.
4. Abort: req 1 drops avail during WAIT, ack arrives -> req_done[1] stays 0, slot 1 unchanged, next grant goes to req 2.
5. Reset mid-WAIT: rst pulsed 1 cycle while mem_req=1 -> next cycle all outputs 0; a stray mem_ack the cycle after is ignored.
6. r_en and w_en both set on req 0 -> mem_we=1 and data written.
